// File: rtl/sys_out_sched.sv
// Pass scheduler for the systolic-array writeback into the sys_out DPR, sharing its address port with a reader.
// Optional build macro SYS_OUT_B2B_EN: a start seen in DONE relaunches immediately (no IDLE gap).
module sys_out_sched #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned ARRAY_LAT    = 8,
  parameter int unsigned N_FEATURES   = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    array_en,
  input  logic                    rd_req,
  input  logic [FEATURE_BITS-1:0] rd_addr,
  output logic                    rd_gnt,
  output logic                    dpr_we,
  output logic [FEATURE_BITS-1:0] dpr_addr
);

  localparam int unsigned LAT_W = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;
  localparam logic [LAT_W-1:0]        LAT_LOAD = LAT_W'(ARRAY_LAT - 1);
  localparam logic [FEATURE_BITS-1:0] WR_LAST  = FEATURE_BITS'(N_FEATURES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_LAT = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [FEATURE_BITS-1:0] wr_cnt_q, wr_cnt_d;

  // State and counter registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Next-state: latency wait, then one write per cycle; counters saturate at their terminal value
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WAIT_LAT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      ST_WAIT_LAT: begin
        if (lat_cnt_q == '0) begin
          state_d  = ST_WRITE;
          wr_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_WRITE: begin
        if (wr_cnt_q == WR_LAST) begin
          state_d = ST_DONE;
        end else begin
          wr_cnt_d = wr_cnt_q + FEATURE_BITS'(1);
        end
      end
      ST_DONE: begin
`ifdef SYS_OUT_B2B_EN
        if (start) begin
          state_d   = ST_WAIT_LAT;
          lat_cnt_d = LAT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status decode from registered state; DPR port muxed with writeback taking priority
  always_comb begin
    busy     = (state_q != ST_IDLE);
    array_en = (state_q == ST_WAIT_LAT) || (state_q == ST_WRITE);
    done     = (state_q == ST_DONE);
    dpr_we   = (state_q == ST_WRITE);
    rd_gnt   = rd_req && (state_q != ST_WRITE);
    dpr_addr = '0;
    if (state_q == ST_WRITE) begin
      dpr_addr = wr_cnt_q;
    end else if (rd_gnt) begin
      dpr_addr = rd_addr;
    end
  end

endmodule

// File: tb/tb_sys_out_sched.sv
// Scoreboard bench for sys_out_sched: per-cycle expectations from a pass timeline, compared at negedge.
module tb_sys_out_sched;

  localparam int unsigned FB  = 4;
  localparam int unsigned LAT = 8;
  localparam int unsigned NF  = 16;

  logic          sys_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic          rd_req  = 1'b0;
  logic [FB-1:0] rd_addr = '0;
  logic          busy, done, array_en, rd_gnt, dpr_we;
  logic [FB-1:0] dpr_addr;

  sys_out_sched #(.FEATURE_BITS(FB), .ARRAY_LAT(LAT), .N_FEATURES(NF)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .array_en(array_en),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_gnt  (rd_gnt),
    .dpr_we  (dpr_we),
    .dpr_addr(dpr_addr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int            sc;
    int            cy;
    logic          busy;
    logic          done;
    logic          array_en;
    logic          rd_gnt;
    logic          dpr_we;
    logic [FB-1:0] dpr_addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs t cycles after the edge that accepted start (t<=0 or past DONE means idle)
  function automatic exp_t ref_out(input int sc, input int cy, input int t,
                                   input logic rq, input logic [FB-1:0] ra);
    exp_t e;
    logic wr;
    wr         = (t >= LAT + 1) && (t <= LAT + NF);
    e.sc       = sc;
    e.cy       = cy;
    e.busy     = (t >= 1) && (t <= LAT + NF + 1);
    e.array_en = (t >= 1) && (t <= LAT + NF);
    e.done     = (t == LAT + NF + 1);
    e.dpr_we   = wr;
    e.rd_gnt   = rq && !wr;
    e.dpr_addr = wr ? FB'(t - LAT - 1) : (e.rd_gnt ? ra : '0);
    return e;
  endfunction

  // Inputs for the cycle following this edge; start/reset take effect at the next edge
  task automatic tick(input logic st, input logic rs, input logic rq, input logic [FB-1:0] ra,
                      input bit chk, input exp_t e);
    @(posedge sys_clk);
    #1;
    start   = st;
    reset   = rs;
    rd_req  = rq;
    rd_addr = ra;
    if (chk) exp_q.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check_eq($sformatf("s%0d c%0d busy", cur.sc, cur.cy), 32'(busy), 32'(cur.busy));
      check_eq($sformatf("s%0d c%0d done", cur.sc, cur.cy), 32'(done), 32'(cur.done));
      check_eq($sformatf("s%0d c%0d array_en", cur.sc, cur.cy), 32'(array_en), 32'(cur.array_en));
      check_eq($sformatf("s%0d c%0d dpr_we", cur.sc, cur.cy), 32'(dpr_we), 32'(cur.dpr_we));
      check_eq($sformatf("s%0d c%0d rd_gnt", cur.sc, cur.cy), 32'(rd_gnt), 32'(cur.rd_gnt));
      check_eq($sformatf("s%0d c%0d dpr_addr", cur.sc, cur.cy), 32'(dpr_addr), 32'(cur.dpr_addr));
    end
  end

  exp_t nul;
  int   o2;
  logic rq_r;
  logic [FB-1:0] ra_r;

  initial begin
    nul = ref_out(0, 0, 0, 1'b0, '0);
    // reset: state undefined before the first edge, then IDLE while reset is held
    tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, nul);
    tick(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, ref_out(0, 1, 0, 1'b1, 4'd9));
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, ref_out(0, 2, 0, 1'b0, 4'd0));

    // reader granted in IDLE
    tick(1'b0, 1'b0, 1'b1, 4'd5, 1'b1, ref_out(2, 0, 0, 1'b1, 4'd5));

    // single pass
    for (int c = 0; c <= 27; c++)
      tick(c == 0, 1'b0, 1'b0, 4'd0, 1'b1, ref_out(1, c, c, 1'b0, 4'd0));

    // reader held through a pass
    for (int c = 0; c <= 27; c++)
      tick(c == 0, 1'b0, 1'b1, 4'd3, 1'b1, ref_out(3, c, c, 1'b1, 4'd3));

    // start held high: relaunch from DONE (b2b) or from the following IDLE cycle
`ifdef SYS_OUT_B2B_EN
    o2 = 25;
`else
    o2 = 26;
`endif
    for (int c = 0; c <= o2 + 27; c++)
      tick(c <= o2 + 5, 1'b0, 1'b0, 4'd0, 1'b1,
           (c <= 25) ? ref_out(4, c, c, 1'b0, 4'd0) : ref_out(4, c, c - o2, 1'b0, 4'd0));

    // reset mid-write at address 6, then a clean pass
    for (int c = 0; c <= 15; c++)
      tick(c == 0, c == 15, 1'b0, 4'd0, 1'b1, ref_out(5, c, c, 1'b0, 4'd0));
    for (int c = 16; c <= 20; c++)
      tick(c == 20, 1'b0, 1'b0, 4'd0, 1'b1, ref_out(5, c, 0, 1'b0, 4'd0));
    for (int c = 21; c <= 47; c++)
      tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, ref_out(5, c, c - 20, 1'b0, 4'd0));

    // random reader traffic across a pass
    for (int c = 0; c <= 27; c++) begin
      rq_r = 1'($urandom_range(0, 1));
      ra_r = FB'($urandom_range(0, 15));
      tick(c == 0, 1'b0, rq_r, ra_r, 1'b1, ref_out(7, c, c, rq_r, ra_r));
    end

    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, nul);
    @(negedge sys_clk);
    #1;
    check_eq("queue drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
